iram_load_ctrl: RTL and testbench

- Controller that owns the instruction-RAM port and shares it between CPU fetch and a host program loader.
- In RUN it passes the CPU byte PC through as a word address (PC[7:1]).
- During a load it stalls the CPU and writes host words sequentially from word 0. It then zero-fills the remaining words, pulses a CPU reset, and returns the port to the CPU.

---
 rtl/iram_load_ctrl.sv | 138 +++++++++++++
 tb/tb_iram_load_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iram_load_ctrl.sv
// Instruction-RAM port arbiter: CPU fetch in RUN, host program load with
// zero-fill of the unused tail and a one-cycle CPU reset pulse afterwards.
module iram_load_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [7:0]    cpu_addr,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_stall,
  output logic          cpu_reset,
  output logic          busy,
  output logic [AW:0]   word_count,
  output logic          ovf
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   word_count_q, word_count_d;
  logic          ovf_q, ovf_d;

  // Next-state computation for the load sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_RUN: begin
        if (ld_start) begin
          state_d      = ST_LOAD;
          ptr_d        = {AW{1'b0}};
          word_count_d = {(AW+1){1'b0}};
          ovf_d        = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          word_count_d = word_count_q + (AW+1)'(1);
          // The final RAM word ends the load whether or not the host flagged it.
          if (ptr_q == LAST_PTR) begin
            state_d = ST_RELEASE;
            ovf_d   = ~ld_last;
          end else if (ld_last) begin
            ptr_d   = ptr_q + AW'(1);
            state_d = ST_CLEAR;
          end else begin
            ptr_d   = ptr_q + AW'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RELEASE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
        ptr_d   = {AW{1'b0}};
      end
      default: begin
        state_d = ST_RUN;
        ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      ptr_q        <= {AW{1'b0}};
      word_count_q <= {(AW+1){1'b0}};
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      ovf_q        <= ovf_d;
    end
  end

  // RAM port and CPU control decode from the current state.
  always_comb begin
    busy      = (state_q != ST_RUN);
    cpu_stall = (state_q != ST_RUN);
    ld_ready  = (state_q == ST_LOAD);
    cpu_reset = (state_q == ST_RELEASE);
    mem_addr  = cpu_addr[7:1];
    mem_we    = 1'b0;
    mem_wdata = {DW{1'b0}};
    case (state_q)
      ST_LOAD: begin
        mem_addr  = ptr_q;
        mem_wdata = ld_data;
        mem_we    = ld_valid;
      end
      ST_CLEAR: begin
        mem_addr  = ptr_q;
        mem_we    = 1'b1;
      end
      ST_RUN, ST_RELEASE: begin
        mem_addr  = cpu_addr[7:1];
      end
      default: begin
        mem_addr  = cpu_addr[7:1];
      end
    endcase
  end

  assign word_count = word_count_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_iram_load_ctrl.sv
// Self-checking bench for iram_load_ctrl: a write-index model checked every
// cycle, plus literal expectations for stall length, RAM image and counters.
module tb_iram_load_ctrl;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [7:0]    cpu_addr = 8'h1A;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = 16'h0000;
  logic          ld_last = 1'b0;
  logic          ld_ready, mem_we, cpu_stall, cpu_reset, busy, ovf;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   word_count;

  iram_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET), .cpu_addr(cpu_addr), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .cpu_reset(cpu_reset),
    .busy(busy), .word_count(word_count), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load session is a run of DEPTH sequential writes (host words, then zeros).
  bit          m_valid = 1'b0;
  bit          m_active, m_loading, m_rel, m_ovf;
  int          m_widx, m_wc;
  // Observed side effects of the DUT.
  logic [DW-1:0] dut_ram [DEPTH];
  int          stall_cnt, rst_pulses, n_writes;

  always @(negedge CLK) begin
    bit          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    e_we    = m_active && (m_loading ? ld_valid : 1'b1);
    e_addr  = m_active ? AW'(m_widx) : cpu_addr[7:1];
    e_wdata = (m_active && m_loading) ? ld_data : 16'h0000;
    if (m_valid) begin
      chk("busy", busy, m_active | m_rel);
      chk("cpu_stall", cpu_stall, m_active | m_rel);
      chk("ld_ready", ld_ready, m_active & m_loading);
      chk("cpu_reset", cpu_reset, m_rel);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      chk("word_count", word_count, m_wc);
      chk("ovf", ovf, m_ovf);
    end
    if (mem_we === 1'b1) begin
      dut_ram[mem_addr] = mem_wdata;
      n_writes++;
    end
    if (cpu_stall === 1'b1) stall_cnt++;
    if (cpu_reset === 1'b1) rst_pulses++;
    // Advance the model to what the next rising edge produces.
    if (RESET) begin
      m_valid = 1'b1; m_active = 1'b0; m_loading = 1'b0; m_rel = 1'b0;
      m_widx = 0; m_wc = 0; m_ovf = 1'b0;
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (m_active) begin
      if (e_we) begin
        m_widx++;
        if (m_loading) begin
          m_wc++;
          if (m_widx == DEPTH) begin
            m_ovf = !ld_last; m_loading = 1'b0;
          end else if (ld_last) begin
            m_loading = 1'b0;
          end
        end
      end
      if (m_widx == DEPTH) begin
        m_active = 1'b0; m_rel = 1'b1;
      end
    end else if (ld_start) begin
      m_active = 1'b1; m_loading = 1'b1; m_widx = 0; m_wc = 0; m_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < DEPTH; i++) dut_ram[i] = 16'hDEAD;
    stall_cnt = 0; rst_pulses = 0; n_writes = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Start a load; gap cycles of ld_valid=0 are inserted after word 0.
  task automatic send_words(input int n, input bit use_last, input int gap, input logic [DW-1:0] base);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      case (i)
        0: ld_data = (base == 16'h0000) ? 16'hF001 : base;
        1: ld_data = (base == 16'h0000) ? 16'hF491 : base + DW'(1);
        2: ld_data = (base == 16'h0000) ? 16'hF249 : base + DW'(2);
        default: ld_data = base + DW'(i);
      endcase
      ld_last = use_last && (i == n - 1);
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      if (i == 0) repeat (gap) tick();
    end
    ld_data = 16'h0000;
  endtask

  task automatic check_small_image(input string name);
    bit ok = 1'b1;
    chk({name, "_ram0"}, dut_ram[0], 16'hF001);
    chk({name, "_ram1"}, dut_ram[1], 16'hF491);
    chk({name, "_ram2"}, dut_ram[2], 16'hF249);
    for (int i = 3; i < DEPTH; i++) if (dut_ram[i] !== 16'h0000) ok = 1'b0;
    chk({name, "_zero_tail"}, ok, 1'b1);
  endtask

  initial begin
    repeat (2) tick();
    RESET = 1'b0;
    // Reset state with byte PC 0x1A -> word 0x0D.
    chk("rst_mem_addr", mem_addr, 7'h0D);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_cpu_reset", cpu_reset, 1'b0);
    chk("rst_word_count", word_count, 8'd0);
    cpu_addr = 8'h37;
    tick();
    chk("run_odd_pc", mem_addr, 7'h1B);

    // Three-word load, back to back.
    clear_obs();
    send_words(3, 1'b1, 0, 16'h0000);
    wait_idle("load3");
    tick();
    check_small_image("load3");
    chk("load3_stall", stall_cnt, 129);
    chk("load3_rstpulse", rst_pulses, 1);
    chk("load3_writes", n_writes, 128);
    chk("load3_wc", word_count, 8'd3);
    chk("load3_ovf", ovf, 1'b0);

    // Same load with a five-cycle valid gap after the first word.
    clear_obs();
    send_words(3, 1'b1, 5, 16'h0000);
    wait_idle("gap");
    tick();
    check_small_image("gap");
    chk("gap_stall", stall_cnt, 134);
    chk("gap_writes", n_writes, 128);

    // Full-depth load without ld_last.
    clear_obs();
    send_words(DEPTH, 1'b0, 0, 16'h1000);
    wait_idle("full");
    tick();
    chk("full_ram127", dut_ram[127], 16'h107F);
    chk("full_ram5", dut_ram[5], 16'h1005);
    chk("full_stall", stall_cnt, 129);
    chk("full_writes", n_writes, 128);
    chk("full_wc", word_count, 8'd128);
    chk("full_ovf", ovf, 1'b1);

    // Reset in the middle of a load.
    clear_obs();
    cpu_addr = 8'h52;
    send_words(2, 1'b0, 0, 16'h0000);
    chk("mid_busy_before", busy, 1'b1);
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("mid_stall", cpu_stall, 1'b0);
    chk("mid_wc", word_count, 8'd0);
    chk("mid_addr", mem_addr, 7'h29);
    chk("mid_ovf", ovf, 1'b0);
    tick();

    // ld_start during CLEAR and ld_valid in CLEAR/RUN are ignored.
    clear_obs();
    send_words(3, 1'b1, 0, 16'h0000);
    repeat (10) tick();
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 16'hBEEF; tick();
    ld_start = 1'b0; tick();
    ld_valid = 1'b0;
    wait_idle("ign");
    ld_valid = 1'b1; ld_data = 16'hCAFE; ld_last = 1'b1;
    repeat (3) tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check_small_image("ign");
    chk("ign_stall", stall_cnt, 129);
    chk("ign_rstpulse", rst_pulses, 1);
    chk("ign_writes", n_writes, 128);
    chk("ign_wc", word_count, 8'd3);
    chk("ign_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
